// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one DVI channel: finds the 10-bit symbol boundary
// by hunting for runs of control tokens, then decodes data bytes and control tokens.
module tmds_decoder #(
    parameter int LOCK_RUN     = 8,
    parameter int SLIP_TIMEOUT = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] word_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);
    localparam int RUN_W = $clog2(LOCK_RUN + 1);
    localparam int TMO_W = $clog2(SLIP_TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(LOCK_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(SLIP_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state, state_n;
    logic [9:0]        prev;
    logic [3:0]        offset, offset_n, offset_inc;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_n;
    logic [19:0]       span;
    logic [9:0]        window;
    logic [2:0]        tok;

    // Returns {hit, value}; hit is 0 for any non-token window.
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        case (w)
            10'h354: token_lookup = 3'b100;
            10'h0AB: token_lookup = 3'b101;
            10'h154: token_lookup = 3'b110;
            10'h2AB: token_lookup = 3'b111;
            default: token_lookup = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] decode_data(input logic [9:0] q);
        logic [7:0] b;
        logic [7:0] d;
        b = q[9] ? ~q[7:0] : q[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

    assign span       = {word_in, prev};
    assign window     = span[offset +: 10];
    assign tok        = token_lookup(window);
    assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    assign locked_out = (state == LOCKED);
    assign offset_out = offset;

    always_comb begin
        state_n  = state;
        run_n    = run_cnt;
        tmo_n    = tmo_cnt;
        offset_n = offset;
        if (valid_in) begin
            case (state)
                SEARCH: begin
                    run_n = tok[2] ? run_cnt + RUN_ONE : '0;
                    // A completed run takes priority over a coincident timeout.
                    if (run_n == RUN_LIM) begin
                        state_n = LOCKED;
                        run_n   = '0;
                        tmo_n   = '0;
                    end else begin
                        tmo_n = tmo_cnt + TMO_ONE;
                        if (tmo_n == TMO_LIM) begin
                            offset_n = offset_inc;
                            run_n    = '0;
                            tmo_n    = '0;
                        end
                    end
                end
                LOCKED: begin
                    tmo_n = tok[2] ? '0 : tmo_cnt + TMO_ONE;
                    if (tmo_n == TMO_LIM) begin
                        state_n  = SEARCH;
                        offset_n = offset_inc;
                        run_n    = '0;
                        tmo_n    = '0;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= SEARCH;
            prev        <= '0;
            offset      <= '0;
            run_cnt     <= '0;
            tmo_cnt     <= '0;
            data_out    <= '0;
            control_out <= '0;
            de_out      <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            state     <= state_n;
            offset    <= offset_n;
            run_cnt   <= run_n;
            tmo_cnt   <= tmo_n;
            // Emission depends on the state before this word was evaluated.
            valid_out <= valid_in && (state == LOCKED);
            if (valid_in) begin
                prev <= word_in;
                if (tok[2]) begin
                    de_out      <= 1'b0;
                    control_out <= tok[1:0];
                    data_out    <= '0;
                end else begin
                    de_out   <= 1'b1;
                    data_out <= decode_data(window);
                end
            end
        end
    end
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder with a word-level reference model compared every cycle.
module tb_tmds_decoder;
    localparam int LR = 8;
    localparam int ST = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] word = '0;
    logic       valid = 1'b0;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       de_out, valid_out, locked_out;
    logic [3:0] offset_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tmds_decoder #(.LOCK_RUN(LR), .SLIP_TIMEOUT(ST)) dut (
        .clk_in(clk), .rst_in(rst_n), .word_in(word), .valid_in(valid),
        .data_out(data_out), .control_out(control_out), .de_out(de_out),
        .valid_out(valid_out), .locked_out(locked_out), .offset_out(offset_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-level rules with plain integers.
    function automatic int token_of(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] data_of(input logic [9:0] q);
        logic [7:0] b;
        logic [7:0] d;
        b = q[7:0];
        if (q[9]) b = ~b;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) d[i] = q[8] ? (b[i] ^ b[i-1]) : !(b[i] ^ b[i-1]);
        return d;
    endfunction

    logic [9:0] m_prev;
    int         m_off, m_run, m_tmo;
    bit         m_lk;
    logic [7:0] e_data;
    logic [1:0] e_ctrl;
    logic       e_de, e_vld;

    int         n_off, n_run, n_tmo;
    bit         n_lk;
    logic [7:0] n_data;
    logic [1:0] n_ctrl;
    logic       n_de;

    always_comb begin
        logic [19:0] sp;
        int tok;
        n_off = m_off; n_run = m_run; n_tmo = m_tmo; n_lk = m_lk;
        n_data = e_data; n_ctrl = e_ctrl; n_de = e_de;
        sp = {word, m_prev} >> m_off;
        tok = token_of(sp[9:0]);
        if (tok >= 0) begin
            n_de = 1'b0; n_ctrl = 2'(tok); n_data = 8'h00;
        end else begin
            n_de = 1'b1; n_data = data_of(sp[9:0]);
        end
        if (!m_lk) begin
            n_run = (tok >= 0) ? m_run + 1 : 0;
            if (n_run == LR) begin
                n_lk = 1'b1; n_run = 0; n_tmo = 0;
            end else begin
                n_tmo = m_tmo + 1;
                if (n_tmo == ST) begin
                    n_off = (m_off + 1) % 10; n_run = 0; n_tmo = 0;
                end
            end
        end else begin
            n_tmo = (tok >= 0) ? 0 : m_tmo + 1;
            if (n_tmo == ST) begin
                n_lk = 1'b0; n_off = (m_off + 1) % 10; n_run = 0; n_tmo = 0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev <= '0; m_off <= 0; m_run <= 0; m_tmo <= 0; m_lk <= 1'b0;
            e_data <= '0; e_ctrl <= '0; e_de <= 1'b0; e_vld <= 1'b0;
        end else if (valid) begin
            e_vld  <= m_lk;
            m_prev <= word;
            m_off  <= n_off; m_run <= n_run; m_tmo <= n_tmo; m_lk <= n_lk;
            e_data <= n_data; e_ctrl <= n_ctrl; e_de <= n_de;
        end else begin
            e_vld <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid_out", valid_out, e_vld);
        chk("cmp_locked_out", locked_out, m_lk);
        chk("cmp_offset_out", offset_out, m_off);
        chk("cmp_de_out", de_out, e_de);
        chk("cmp_control_out", control_out, e_ctrl);
        chk("cmp_data_out", data_out, e_data);
    end

    task automatic step(input logic [9:0] w, input logic v);
        word  = w;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(10'h000, 1'b0);
        step(10'h000, 1'b0);
        rst_n = 1'b1;
        step(10'h000, 1'b0);
    endtask

    initial begin
        step(10'h000, 1'b0);
        step(10'h000, 1'b0);
        rst_n = 1'b1;
        step(10'h000, 1'b0);
        chk("post_reset_locked", locked_out, 0);
        chk("post_reset_offset", offset_out, 0);
        chk("post_reset_valid", valid_out, 0);

        // Aligned lock followed by a short decode sequence.
        for (int i = 0; i < 8; i++) step(10'h354, 1'b1);
        chk("aligned_prelock", locked_out, 0);
        step(10'h354, 1'b1);
        chk("aligned_lock", locked_out, 1);
        chk("aligned_lock_word_not_emitted", valid_out, 0);
        step(10'h100, 1'b1);
        chk("tok9_valid", valid_out, 1);
        chk("tok9_de", de_out, 0);
        chk("tok9_ctrl", control_out, 0);
        step(10'h2FF, 1'b1);
        chk("d100_de", de_out, 1);
        chk("d100_data", data_out, 8'h00);
        step(10'h0AB, 1'b1);
        chk("d2ff_de", de_out, 1);
        chk("d2ff_data", data_out, 8'hFE);
        step(10'h2AB, 1'b1);
        chk("c0ab_de", de_out, 0);
        chk("c0ab_ctrl", control_out, 1);
        step(10'h354, 1'b1);
        chk("c2ab_de", de_out, 0);
        chk("c2ab_ctrl", control_out, 3);

        // Asynchronous reset in the middle of a cycle.
        step(10'h100, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", data_out, 0);
        chk("async_rst_ctrl", control_out, 0);
        chk("async_rst_de", de_out, 0);
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_locked", locked_out, 0);
        chk("async_rst_offset", offset_out, 0);
        step(10'h000, 1'b0);
        step(10'h000, 1'b0);
        rst_n = 1'b1;
        step(10'h000, 1'b0);
        chk("release_locked", locked_out, 0);
        chk("release_offset", offset_out, 0);

        // Loss of lock after a run of data windows.
        for (int i = 0; i < 9; i++) step(10'h354, 1'b1);
        chk("loss_locked", locked_out, 1);
        for (int i = 1; i <= 17; i++) begin
            step(10'h100, 1'b1);
            if (i == 16) chk("loss_still_locked", locked_out, 1);
            if (i == 17) begin
                chk("loss_unlock", locked_out, 0);
                chk("loss_last_emitted", valid_out, 1);
                chk("loss_last_de", de_out, 1);
                chk("loss_offset_inc", offset_out, 1);
            end
        end
        step(10'h100, 1'b1);
        chk("loss_no_emit_after", valid_out, 0);

        // Lock and timeout on the same word: lock wins.
        do_reset();
        for (int i = 0; i < 7; i++) step(10'h000, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step(10'h354, 1'b1);
            if (i == 8) chk("simul_prelock", locked_out, 0);
        end
        chk("simul_lock", locked_out, 1);
        chk("simul_offset_kept", offset_out, 0);

        // Slip search on a stream delayed by 3 bits.
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            step(10'h2A6, 1'b1);
            if (i == 15) chk("slip_off0", offset_out, 0);
            if (i == 16) chk("slip_off1", offset_out, 1);
            if (i == 32) chk("slip_off2", offset_out, 2);
            if (i == 48) chk("slip_off3", offset_out, 3);
            if (i == 55) chk("slip_prelock", locked_out, 0);
            if (i == 56) begin
                chk("slip_lock", locked_out, 1);
                chk("slip_lock_offset", offset_out, 3);
            end
            if (i == 57) begin
                chk("slip_emit_valid", valid_out, 1);
                chk("slip_emit_de", de_out, 0);
                chk("slip_emit_ctrl", control_out, 0);
            end
        end

        // Gapped valid: idle cycles must not count.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step(10'h354, 1'b1);
            chk("gap_lock_state", locked_out, (k == 9) ? 1 : 0);
            for (int g = 0; g < 5; g++) begin
                step(10'h000, 1'b0);
                chk("gap_no_valid", valid_out, 0);
            end
        end
        step(10'h354, 1'b1);
        chk("gap_emit_valid", valid_out, 1);
        chk("gap_emit_de", de_out, 0);

        // Offset wrap after ten slips.
        do_reset();
        for (int i = 1; i <= 165; i++) begin
            step(10'h000, 1'b1);
            if (i == 144) chk("wrap_off9", offset_out, 9);
            if (i == 160) begin
                chk("wrap_off0", offset_out, 0);
                chk("wrap_unlocked", locked_out, 0);
            end
        end

        step(10'h000, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
